// File: rtl/data_mem_resp.sv
// data_mem_resp: target side of the CPU data-memory request/response handshake.
// Accepts one request at a time, waits WAIT_CYCLES, then services it from an internal
// byte-addressed little-endian RAM and returns load data or an error flag.
//
// Ports:
//   clk, rst_n          single clock, synchronous active-low reset
//   req_valid/req_ready request handshake (req_ready is registered)
//   req_we              1 = store, 0 = load
//   req_funct3          RV32I size code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr            byte address
//   req_wdata           store data, low-order bytes used for SB/SH
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata           load result; 0 for stores and errors
//   rsp_err             request rejected (out of range, misaligned, illegal funct3)
module data_mem_resp #(
    parameter int unsigned ADDR_BITS   = 12,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned Words    = 2 ** (ADDR_BITS - 2);
    localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [Words];

    logic [ADDR_BITS-3:0] word_idx;
    logic [31:0]          word;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic                 range_err;
    logic                 misaligned;
    logic                 bad_funct3;
    logic                 err_c;
    logic [31:0]          rdata_c;
    logic [3:0]           wmask_c;
    logic [31:0]          wdata_c;

    assign word_idx = addr_q[ADDR_BITS-1:2];
    assign word     = mem[word_idx];
    assign byte_sel = word[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = addr_q[1] ? word[31:16] : word[15:0];

    // Decode the latched request: error flags, load result, store lane mask and lane data.
    always_comb begin
        misaligned = 1'b0;
        bad_funct3 = 1'b0;
        rdata_c    = '0;
        wmask_c    = '0;
        wdata_c    = '0;
        range_err  = |(addr_q >> ADDR_BITS);
        case (funct3_q)
            3'd0: begin
                rdata_c = {{24{byte_sel[7]}}, byte_sel};
                wmask_c = 4'b0001 << addr_q[1:0];
                wdata_c = {4{wdata_q[7:0]}};
            end
            3'd1: begin
                misaligned = addr_q[0];
                rdata_c    = {{16{half_sel[15]}}, half_sel};
                wmask_c    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_c    = {2{wdata_q[15:0]}};
            end
            3'd2: begin
                misaligned = (addr_q[1:0] != 2'b00);
                rdata_c    = word;
                wmask_c    = 4'b1111;
                wdata_c    = wdata_q;
            end
            3'd4: begin
                bad_funct3 = we_q;
                rdata_c    = {24'd0, byte_sel};
            end
            3'd5: begin
                bad_funct3 = we_q;
                misaligned = addr_q[0];
                rdata_c    = {16'd0, half_sel};
            end
            default: bad_funct3 = 1'b1;
        endcase
        err_c = range_err | misaligned | bad_funct3;
        if (err_c || we_q) begin
            rdata_c = '0;
        end
        if (err_c || !we_q) begin
            wmask_c = '0;
        end
    end

    // RAM is never reset; a write only lands if reset is not asserted on the access edge.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == StAccess) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_c[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_c[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_ready && req_valid) begin
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        cnt_q     <= WaitInit;
                        req_ready <= 1'b0;
                        state_q   <= (WAIT_CYCLES == 0) ? StAccess : StWait;
                    end else begin
                        // Covers the first cycle after reset release.
                        req_ready <= 1'b1;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    rsp_rdata <= rdata_c;
                    rsp_err   <= err_c;
                    rsp_valid <= 1'b1;
                    state_q   <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Testbench for data_mem_resp: directed test-plan steps followed by randomized loads and
// stores, all checked against a byte-array reference model of the RAM.
module tb_data_mem_resp;

    localparam int unsigned AddrBits   = 12;
    localparam int unsigned WaitCycles = 1;
    localparam int unsigned MemBytes   = 1 << AddrBits;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mem_m [MemBytes];

    data_mem_resp #(
        .ADDR_BITS   (AddrBits),
        .WAIT_CYCLES (WaitCycles)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed little-endian array; updates the model on legal stores.
    function automatic void ref_model(input logic we, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] wd,
                                      output logic [31:0] rd, output logic er);
        int  n;
        bit  legal;
        bit  sgn;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n     = 1 << f3[1:0];
        sgn   = !we && !f3[2];
        er    = !legal || (a >= MemBytes) || ((a % n) != 0);
        rd    = '0;
        if (!er) begin
            if (we) begin
                for (int i = 0; i < n; i++) mem_m[a + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) rd = rd | (32'(mem_m[a + i]) << (8 * i));
                if (sgn && n < 4 && rd[8*n-1]) rd = rd | ~((32'd1 << (8 * n)) - 32'd1);
            end
        end
    endfunction

    // Issue one request from a negedge and check the response; hold > 0 applies
    // backpressure for that many cycles while a competing request is offered.
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold, input string tag);
        logic [31:0] erd;
        logic        eer;
        logic [31:0] held;
        int          k;
        ref_model(we, f3, a, wd, erd, eer);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        rsp_ready  = (hold == 0);
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_accept"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        // Request is latched: scramble the inputs to show they no longer matter.
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        k = 0;
        while (!rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, 32'(k), 32'(WaitCycles + 1));
        chk({tag, "_rdata"}, rsp_rdata, erd);
        chk({tag, "_err"}, 32'(rsp_err), 32'(eer));
        if (hold > 0) begin
            held = rsp_rdata;
            for (int i = 0; i < hold; i++) begin
                req_valid = 1'b1;
                @(negedge clk);
                chk({tag, "_bp_valid"}, 32'(rsp_valid), 32'd1);
                chk({tag, "_bp_rdata"}, rsp_rdata, held);
                chk({tag, "_bp_ready"}, 32'(req_ready), 32'd0);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        logic        we;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_req_ready", 32'(req_ready), 32'd1);

        // Give the low 256 bytes known contents.
        for (int w = 0; w < 64; w++) do_txn(1'b1, 3'd2, 32'(w * 4), $urandom, 0, "init");

        do_txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, "sw10");
        do_txn(1'b0, 3'd2, 32'h10, 32'h0, 0, "lw10");
        do_txn(1'b0, 3'd0, 32'h13, 32'h0, 0, "lb13");
        do_txn(1'b0, 3'd4, 32'h13, 32'h0, 0, "lbu13");
        do_txn(1'b0, 3'd1, 32'h10, 32'h0, 0, "lh10");
        do_txn(1'b0, 3'd5, 32'h12, 32'h0, 0, "lhu12");
        do_txn(1'b1, 3'd0, 32'h11, 32'h000000AA, 0, "sb11");
        do_txn(1'b0, 3'd2, 32'h10, 32'h0, 0, "lw10_sb");
        do_txn(1'b1, 3'd1, 32'h12, 32'h00001234, 0, "sh12");
        do_txn(1'b0, 3'd2, 32'h10, 32'h0, 0, "lw10_sh");
        do_txn(1'b0, 3'd2, 32'h12, 32'h0, 0, "lw12_mis");
        do_txn(1'b1, 3'd2, 32'h1000, 32'hCAFEF00D, 0, "sw1000_range");
        do_txn(1'b0, 3'd2, 32'h0, 32'h0, 0, "lw0_after_range");
        do_txn(1'b0, 3'd3, 32'h0, 32'h0, 0, "ld_f3_3");
        do_txn(1'b0, 3'd2, 32'h10, 32'h0, 5, "backpressure");

        // Reset while the store sits in its wait state: it must be dropped.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h20;
        req_wdata  = 32'h55AA55AA;
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
        chk("midrst_rsp_err", 32'(rsp_err), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        do_txn(1'b0, 3'd2, 32'h20, 32'h0, 0, "lw20_after_rst");

        for (int t = 0; t < 150; t++) begin
            we = 1'($urandom);
            f3 = 3'($urandom);
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            if ($urandom_range(0, 7) == 0) a = a | ($urandom << AddrBits);
            do_txn(we, f3, a, $urandom, 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
